ts_sync_lock: RTL and testbench
===============================

Name: ts_sync_lock

Overview:
- Parametrised MPEG-2 TS sync acquisition and tracking block with hysteresis.
- Sits between the byte-stream front end and the packet parser.
- Acquires on N consecutive sync bytes at packet pitch, then flywheels through up to M-1 corrupted syncs before dropping lock.
- Supports 188- and 204-byte packets. Outputs a registered byte stream with start-of-packet, lock, sync-error and packet count.

Parameters:
- SYNC_BYTE, 8'h47, sync byte value compared at each expected packet start.
- LOCK_CNT, 5, consecutive sync bytes at correct pitch, first included, needed to lock (legal 2..15).
- UNLOCK_CNT, 3, consecutive missed syncs while locked that drop lock (legal 1..15).
- PKT_CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- byte_in  in  8  input TS byte
- byte_valid  in  1  byte_in qualifier; the block advances only on valid bytes
- mode_204  in  1  0 = 188-byte packets, 1 = 204-byte packets (L = 188 or 204)
- byte_out  out  8  byte_in delayed one cycle
- valid_out  out  1  byte_valid delayed one cycle
- sop  out  1  byte_out is a packet-start position while locked
- lock  out  1  level, asserted while in LOCKED
- sync_err  out  1  pulse: expected sync position in LOCKED did not carry SYNC_BYTE
- pkt_cnt  out  PKT_CNT_W  packets started while locked; wraps modulo 2^PKT_CNT_W

Behaviour:
- Reset (rst low, async): state = HUNT, counters = 0, mode register = mode_204, all outputs = 0.
- All outputs are registered with 1-cycle latency. Each valid input byte appears on byte_out/valid_out one cycle later, together with its sop, lock and sync_err.
- Cycle with byte_valid = 0:
  - FSM and counters hold.
  - Next cycle: valid_out = 0, sop = 0, sync_err = 0.
  - byte_out, lock and pkt_cnt hold.
- pos is an 8-bit count of valid bytes since the last packet start. An "expected position" is a valid byte with pos == L - 1, i.e. L bytes after the previous start.
- State HUNT:
  - Valid byte == SYNC_BYTE: go to VERIFY, pos = 0, good = 1.
  - Otherwise stay in HUNT.
- State VERIFY, on each valid byte pos++. At an expected position:
  - byte == SYNC_BYTE: pos = 0, good++.
    - If good + 1 == LOCK_CNT: go to LOCKED, miss = 0, and this byte outputs sop = 1, lock = 1.
  - byte != SYNC_BYTE: go to HUNT. The mismatching byte is not re-evaluated as a new candidate, even if it equals SYNC_BYTE.
- State LOCKED, on each valid byte pos++. At an expected position pos = 0 and:
  - byte == SYNC_BYTE: miss = 0, sop = 1, pkt_cnt++.
  - byte != SYNC_BYTE, miss + 1 < UNLOCK_CNT: miss++, sync_err = 1, sop = 1 (flywheel), pkt_cnt++.
  - byte != SYNC_BYTE, miss + 1 == UNLOCK_CNT: go to HUNT with sync_err = 1, sop = 0, lock = 0 on this byte; pkt_cnt unchanged.
- Bytes at non-expected positions are never checked. A SYNC_BYTE value in the payload has no effect.
- mode_204 is registered every cycle. A change from the registered value forces HUNT on the next edge: lock drops and counters clear, regardless of byte_valid. pkt_cnt is not cleared.
- pkt_cnt clears only on reset.
- Widths:
  - pos is 8 bits, saturating is never needed because L ≤ 204.
  - good and miss are 4 bits.
  - pkt_cnt wraps without a flag.

Test Plan:
- Clean 188 stream, 0x47 at indices 0, 188, 376…, byte_valid = 1 -> lock and sop rise with byte_out of index 752; sop at 940, 1128; pkt_cnt = 1, 2, 3; sync_err never asserted.
- Locked, then byte at index 1316 = 0x00 -> sync_err and sop pulse on it; lock stays 1; next good sync clears miss; pkt_cnt keeps incrementing.
- Locked, then syncs at 1316, 1504 and 1692 corrupted -> three sync_err pulses; lock falls with byte 1692 (sop = 0 there); stream then resumes good syncs from 1880 -> re-lock at 1880 + 4·188 = 2632.
- False 0x47 at index 10, true syncs at 50 + 188k -> VERIFY fails at 198, back to HUNT; candidate at 238; lock at 238 + 752 = 990.
- Same clean stream with byte_valid deasserted on ~30% of cycles at random -> lock/sop on identical valid-byte indices; valid_out equals byte_valid delayed one cycle; outputs hold through gaps.
- mode_204 = 1 with a 204 stream -> lock at index 816. Toggle mode_204 while locked -> lock = 0 two cycles later. Assert rst mid-packet -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ts_sync_lock.sv
// ---------------------------------------------------------------------------
// ts_sync_lock
//   MPEG-2 transport stream sync acquisition and tracking with hysteresis.
//   Sits between the byte-stream front end and the packet parser. A candidate
//   sync byte is verified over LOCK_CNT consecutive packet starts before lock
//   is declared. Once locked, up to UNLOCK_CNT-1 consecutive corrupted syncs
//   are flywheeled through before lock is dropped. 188- and 204-byte packets
//   are supported.
//
// Ports
//   clk         clock
//   rst         asynchronous active-low reset
//   byte_in     input TS byte
//   byte_valid  byte_in qualifier; the block only advances on valid bytes
//   mode_204    0 = 188-byte packets, 1 = 204-byte packets
//   byte_out    byte_in delayed one cycle
//   valid_out   byte_valid delayed one cycle
//   sop         byte_out is a packet start while locked
//   lock        level, high while locked
//   sync_err    pulse: an expected sync position while locked was corrupted
//   pkt_cnt     packets started while locked (wraps)
// ---------------------------------------------------------------------------
module ts_sync_lock #(
  parameter logic [7:0]  SYNC_BYTE  = 8'h47,
  parameter int unsigned LOCK_CNT   = 5,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned PKT_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  input  logic                 mode_204,
  output logic [7:0]           byte_out,
  output logic                 valid_out,
  output logic                 sop,
  output logic                 lock,
  output logic                 sync_err,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0]           LOCK_N   = 5'(LOCK_CNT);
  localparam logic [4:0]           UNLOCK_N = 5'(UNLOCK_CNT);
  localparam logic [PKT_CNT_W-1:0] PKT_ONE  = PKT_CNT_W'(1);

  state_t               state_q, state_d;
  logic [7:0]           pos_q, pos_d;
  logic [3:0]           good_q, good_d;
  logic [3:0]           miss_q, miss_d;
  logic                 mode_q, mode_d;
  logic [7:0]           byte_out_q, byte_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 sop_q, sop_d;
  logic                 lock_q, lock_d;
  logic                 sync_err_q, sync_err_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [7:0] last_pos;
  logic       is_sync;
  logic       at_exp;
  logic [4:0] good_inc;
  logic [4:0] miss_inc;

  // pos counts valid bytes since the last packet start, so the next start
  // is expected when pos has reached L-1.
  assign last_pos = mode_q ? 8'd203 : 8'd187;
  assign is_sync  = (byte_in == SYNC_BYTE);
  assign at_exp   = (pos_q == last_pos);
  assign good_inc = {1'b0, good_q} + 5'd1;
  assign miss_inc = {1'b0, miss_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    mode_d      = mode_204;
    byte_out_d  = byte_out_q;
    valid_out_d = byte_valid;
    sop_d       = 1'b0;
    lock_d      = lock_q;
    sync_err_d  = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;

    if (byte_valid) begin
      byte_out_d = byte_in;
    end

    if (mode_204 != mode_q) begin
      // Packet length changed under us: any acquired phase is meaningless,
      // so restart acquisition. The byte on this edge is not evaluated.
      state_d = HUNT;
      pos_d   = '0;
      good_d  = '0;
      miss_d  = '0;
      lock_d  = 1'b0;
    end else if (byte_valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            pos_d   = '0;
            good_d  = 4'd1;
          end
        end

        VERIFY: begin
          if (at_exp) begin
            if (is_sync) begin
              pos_d = '0;
              if (good_inc == LOCK_N) begin
                state_d   = LOCKED;
                good_d    = '0;
                miss_d    = '0;
                sop_d     = 1'b1;
                pkt_cnt_d = pkt_cnt_q + PKT_ONE;
              end else begin
                good_d = good_inc[3:0];
              end
            end else begin
              // A failed candidate is discarded outright; this byte is not
              // reconsidered as a fresh candidate.
              state_d = HUNT;
              pos_d   = '0;
              good_d  = '0;
            end
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end

        LOCKED: begin
          if (at_exp) begin
            pos_d = '0;
            if (is_sync) begin
              miss_d    = '0;
              sop_d     = 1'b1;
              pkt_cnt_d = pkt_cnt_q + PKT_ONE;
            end else if (miss_inc < UNLOCK_N) begin
              // Flywheel: keep the packet phase and still mark the start.
              miss_d     = miss_inc[3:0];
              sync_err_d = 1'b1;
              sop_d      = 1'b1;
              pkt_cnt_d  = pkt_cnt_q + PKT_ONE;
            end else begin
              state_d    = HUNT;
              good_d     = '0;
              miss_d     = '0;
              sync_err_d = 1'b1;
            end
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end

        default: begin
          state_d = HUNT;
          pos_d   = '0;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
      lock_d = (state_d == LOCKED);
    end
  end

  // Single register stage: state, counters and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      pos_q       <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      mode_q      <= mode_204;
      byte_out_q  <= '0;
      valid_out_q <= 1'b0;
      sop_q       <= 1'b0;
      lock_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      mode_q      <= mode_d;
      byte_out_q  <= byte_out_d;
      valid_out_q <= valid_out_d;
      sop_q       <= sop_d;
      lock_q      <= lock_d;
      sync_err_q  <= sync_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign byte_out  = byte_out_q;
  assign valid_out = valid_out_q;
  assign sop       = sop_q;
  assign lock      = lock_q;
  assign sync_err  = sync_err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_ts_sync_lock.sv
// ---------------------------------------------------------------------------
// tb_ts_sync_lock
//   Directed bench for ts_sync_lock. Each scenario streams a generated TS
//   byte sequence; a table of expected events (sop / lock / sync_err /
//   pkt_cnt at given valid-byte indices) defines the outputs, and every
//   other byte is expected to carry sop = 0, sync_err = 0 with lock and
//   pkt_cnt holding their last tabled values.
// ---------------------------------------------------------------------------
module tb_ts_sync_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        mode_204 = 1'b0;
  logic [7:0]  byte_out;
  logic        valid_out;
  logic        sop;
  logic        lock;
  logic        sync_err;
  logic [15:0] pkt_cnt;

  ts_sync_lock dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .mode_204   (mode_204),
    .byte_out   (byte_out),
    .valid_out  (valid_out),
    .sop        (sop),
    .lock       (lock),
    .sync_err   (sync_err),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   sc;   // scenario
    int   idx;  // valid-byte index
    logic sop;
    logic lk;
    logic err;
    int   cnt;
  } ev_t;

  ev_t ev[$];

  int total = 0;
  int bad   = 0;

  function automatic logic [27:0] outs();
    return {valid_out, byte_out, sop, lock, sync_err, pkt_cnt};
  endfunction

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (vld,byte,sop,lock,err,cnt)", name, act, exp);
    end
  endtask

  // Payload never equals 0x47 so only deliberate sync bytes exist.
  function automatic logic [7:0] gen(input int sc, input int i);
    logic [7:0] p;
    p = 8'((i * 7 + 3) & 255);
    if (p == 8'h47) p = 8'h48;
    case (sc)
      0: if (i % 188 == 0) p = (i == 1316 || i == 1880 || i == 2068) ? 8'h00 : 8'h47;
      1: if (i % 188 == 0) p = (i == 1316 || i == 1504 || i == 1692) ? 8'h00 : 8'h47;
      2: if (i == 10 || (i >= 50 && (i - 50) % 188 == 0)) p = 8'h47;
      3: if (i % 188 == 0) p = 8'h47;
      4: if (i % 204 == 0) p = 8'h47;
      default: ;
    endcase
    return p;
  endfunction

  task automatic push(input logic [7:0] b, input logic v);
    byte_in    = b;
    byte_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst        = 1'b0;
    mode_204   = m;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 28'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_scen(input int sc, input int n, input int gap_pct);
    int         i   = 0;
    int         cyc = 0;
    logic       el  = 1'b0;
    int         ec  = 0;
    logic [7:0] last = 8'h00;
    logic       es;
    logic       ee;
    logic [7:0] b;
    while (i < n) begin
      if (cyc > 4 * n) begin
        total++;
        bad++;
        $display("FAIL s%0d_timeout: got %0d bytes want %0d", sc, i, n);
        break;
      end
      cyc++;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        push(8'($urandom), 1'b0);
        chk($sformatf("s%0d_gap_i%0d", sc, i), outs(),
            {1'b0, last, 1'b0, el, 1'b0, 16'(ec)});
      end else begin
        b  = gen(sc, i);
        push(b, 1'b1);
        es = 1'b0;
        ee = 1'b0;
        foreach (ev[k]) begin
          if (ev[k].sc == sc && ev[k].idx == i) begin
            es = ev[k].sop;
            ee = ev[k].err;
            el = ev[k].lk;
            ec = ev[k].cnt;
          end
        end
        chk($sformatf("s%0d_i%0d", sc, i), outs(),
            {1'b1, b, es, el, ee, 16'(ec)});
        last = b;
        i++;
      end
    end
  endtask

  initial begin
    // Scenario 0: clean 188 stream, single misses separated by good syncs.
    ev.push_back(ev_t'{0,  752, 1'b1, 1'b1, 1'b0, 1});
    ev.push_back(ev_t'{0,  940, 1'b1, 1'b1, 1'b0, 2});
    ev.push_back(ev_t'{0, 1128, 1'b1, 1'b1, 1'b0, 3});
    ev.push_back(ev_t'{0, 1316, 1'b1, 1'b1, 1'b1, 4});
    ev.push_back(ev_t'{0, 1504, 1'b1, 1'b1, 1'b0, 5});
    ev.push_back(ev_t'{0, 1692, 1'b1, 1'b1, 1'b0, 6});
    ev.push_back(ev_t'{0, 1880, 1'b1, 1'b1, 1'b1, 7});
    ev.push_back(ev_t'{0, 2068, 1'b1, 1'b1, 1'b1, 8});
    ev.push_back(ev_t'{0, 2256, 1'b1, 1'b1, 1'b0, 9});
    // Scenario 1: three consecutive misses drop lock, then re-lock.
    ev.push_back(ev_t'{1,  752, 1'b1, 1'b1, 1'b0, 1});
    ev.push_back(ev_t'{1,  940, 1'b1, 1'b1, 1'b0, 2});
    ev.push_back(ev_t'{1, 1128, 1'b1, 1'b1, 1'b0, 3});
    ev.push_back(ev_t'{1, 1316, 1'b1, 1'b1, 1'b1, 4});
    ev.push_back(ev_t'{1, 1504, 1'b1, 1'b1, 1'b1, 5});
    ev.push_back(ev_t'{1, 1692, 1'b0, 1'b0, 1'b1, 5});
    ev.push_back(ev_t'{1, 2632, 1'b1, 1'b1, 1'b0, 6});
    // Scenario 2: false candidate at 10, true syncs at 50 + 188k.
    ev.push_back(ev_t'{2,  990, 1'b1, 1'b1, 1'b0, 1});
    ev.push_back(ev_t'{2, 1178, 1'b1, 1'b1, 1'b0, 2});
    // Scenario 3: clean 188 stream with random gaps.
    ev.push_back(ev_t'{3,  752, 1'b1, 1'b1, 1'b0, 1});
    ev.push_back(ev_t'{3,  940, 1'b1, 1'b1, 1'b0, 2});
    ev.push_back(ev_t'{3, 1128, 1'b1, 1'b1, 1'b0, 3});
    // Scenario 4: 204-byte packets.
    ev.push_back(ev_t'{4,  816, 1'b1, 1'b1, 1'b0, 1});

    do_reset(1'b0);
    run_scen(0, 2300, 0);
    do_reset(1'b0);
    run_scen(1, 2700, 0);
    do_reset(1'b0);
    run_scen(2, 1200, 0);
    do_reset(1'b0);
    run_scen(3, 1200, 30);
    do_reset(1'b1);
    run_scen(4, 830, 0);

    // Mode change while locked: lock gone within two cycles, count kept.
    mode_204 = 1'b0;
    push(gen(4, 830), 1'b1);
    push(gen(4, 831), 1'b1);
    chk("mode_toggle_unlock", 28'({lock, pkt_cnt}), 28'({1'b0, 16'd1}));

    // Reset asserted mid-packet, between clock edges.
    push(gen(4, 832), 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset", outs(), 28'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
